// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue front end for the 32-bit ALU: decode, execute, then hold the outcome until accepted.
// Accept-to-out_valid is 3 edges; out_valid and outcome fields hold while out_ready is low.
module alu_issue_ctrl #(
  parameter logic [2:0] RESET_CTR = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        zero_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  state_t      state;
  logic [31:0] instr_q, rs_q, rt_q;
  logic        legal_q, br_q, bne_q;
  logic [4:0]  dest_q;

  logic [2:0]  dec_ctr;
  logic [31:0] dec_src1, dec_src2;
  logic [4:0]  dec_dest;
  logic        dec_legal, dec_br, dec_bne;

  // Operands arrive on rs_data, so the rs field of the word itself is never decoded.
  logic unused_rs_field;
  assign unused_rs_field = ^instr_q[25:21];

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext;
  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {16'h0000, instr_q[15:0]};

  always_comb begin
    dec_ctr   = RESET_CTR;
    dec_src1  = rs_q;
    dec_src2  = rt_q;
    dec_dest  = instr_q[20:16];
    dec_legal = 1'b1;
    dec_br    = 1'b0;
    dec_bne   = 1'b0;
    case (opcode)
      6'h00: begin
        dec_dest = instr_q[15:11];
        case (funct)
          6'h24:        dec_ctr = 3'b000;
          6'h25:        dec_ctr = 3'b001;
          6'h26:        dec_ctr = 3'b010;
          6'h27:        dec_ctr = 3'b011;
          6'h2A:        dec_ctr = 3'b100;
          6'h20, 6'h21: dec_ctr = 3'b101;
          6'h22, 6'h23: dec_ctr = 3'b110;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec_ctr = 3'b101; dec_src2 = imm_sext; end
      6'h0C:        begin dec_ctr = 3'b000; dec_src2 = imm_zext; end
      6'h0D:        begin dec_ctr = 3'b001; dec_src2 = imm_zext; end
      6'h0E:        begin dec_ctr = 3'b010; dec_src2 = imm_zext; end
      6'h0A:        begin dec_ctr = 3'b100; dec_src2 = imm_sext; end
      6'h04, 6'h05: begin
        dec_ctr = 3'b110;
        dec_br  = 1'b1;
        dec_bne = opcode[0];
      end
      default:      dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_ctr  = RESET_CTR;
      dec_src1 = '0;
      dec_src2 = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_ready  <= 1'b1;
      out_valid    <= 1'b0;
      wb_en        <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctr      <= RESET_CTR;
      instr_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      legal_q      <= 1'b0;
      br_q         <= 1'b0;
      bne_q        <= 1'b0;
      dest_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid) begin
            instr_q     <= instr;
            rs_q        <= rs_data;
            rt_q        <= rt_data;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          alu_src1 <= dec_src1;
          alu_src2 <= dec_src2;
          alu_ctr  <= dec_ctr;
          legal_q  <= dec_legal;
          br_q     <= dec_br;
          bne_q    <= dec_bne;
          dest_q   <= dec_dest;
          state    <= EXEC;
        end
        EXEC: begin
          wb_data      <= alu_result;
          wb_reg       <= dest_q;
          // Writes to $zero are dropped here rather than left to the register file.
          wb_en        <= legal_q && !br_q && (dest_q != 5'd0);
          branch_taken <= br_q && (bne_q ? !zero_bit : zero_bit);
          illegal      <= !legal_q;
          out_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            illegal      <= 1'b0;
            wb_en        <= 1'b0;
            branch_taken <= 1'b0;
            instr_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [2:0]  alu_ctr;
  logic        zero_bit;
  logic        out_valid, out_ready = 1'b1;
  logic        wb_en, branch_taken, illegal;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  int edges;
  logic [31:0] ex_src1, ex_src2;
  logic [2:0]  ex_ctr;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .zero_bit(zero_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always_comb begin
    case (alu_ctr)
      3'b000:  alu_result = alu_src1 & alu_src2;
      3'b001:  alu_result = alu_src1 | alu_src2;
      3'b010:  alu_result = alu_src1 ^ alu_src2;
      3'b011:  alu_result = ~(alu_src1 | alu_src2);
      3'b100:  alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
      3'b101:  alu_result = alu_src1 + alu_src2;
      3'b110:  alu_result = alu_src1 - alu_src2;
      default: alu_result = '0;
    endcase
  end
  assign zero_bit = (alu_src1 == alu_src2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and wait for out_valid; EXEC-cycle ALU inputs are captured on the way.
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; rs_data = a; rt_data = b; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("ready_drop", {31'd0, instr_ready}, 32'd0);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 2) begin
        ex_src1 = alu_src1; ex_src2 = alu_src2; ex_ctr = alu_ctr;
      end
    end
    chk("latency", edges, 32'd3);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_clr", {31'd0, out_valid}, 32'd0);
    chk("ready_back", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ctr", {29'd0, alu_ctr}, 32'd5);
    chk("rst_src1", alu_src1, 32'd0);
    chk("rst_wb", {26'd0, wb_en, wb_reg}, 32'd0);
    rst_n = 1'b1;

    // add $3,$1,$2
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    chk("add_ctr", {29'd0, ex_ctr}, 32'd5);
    chk("add_src1", ex_src1, 32'd5);
    chk("add_src2", ex_src2, 32'd7);
    chk("add_wben", {31'd0, wb_en}, 32'd1);
    chk("add_reg", {27'd0, wb_reg}, 32'd3);
    chk("add_data", wb_data, 32'd12);
    accept();

    // andi $4,$1,0xFFFF
    issue({6'h0C, 5'd1, 5'd4, 16'hFFFF}, 32'h12345678, 32'h0);
    chk("andi_ctr", {29'd0, ex_ctr}, 32'd0);
    chk("andi_src2", ex_src2, 32'h0000FFFF);
    chk("andi_data", wb_data, 32'h00005678);
    chk("andi_reg", {27'd0, wb_reg}, 32'd4);
    accept();

    // slti $5,$1,-1
    issue({6'h0A, 5'd1, 5'd5, 16'hFFFF}, 32'hFFFFFFFE, 32'h0);
    chk("slti_ctr", {29'd0, ex_ctr}, 32'd4);
    chk("slti_src2", ex_src2, 32'hFFFFFFFF);
    chk("slti_data", wb_data, 32'd1);
    accept();

    // sub $6,$1,$2 with negative result
    issue({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h22}, 32'd3, 32'd10);
    chk("sub_ctr", {29'd0, ex_ctr}, 32'd6);
    chk("sub_data", wb_data, 32'hFFFFFFF9);
    accept();

    // beq / bne, equal operands
    issue({6'h04, 5'd1, 5'd2, 16'h0010}, 32'd9, 32'd9);
    chk("beq_ctr", {29'd0, ex_ctr}, 32'd6);
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_wben", {31'd0, wb_en}, 32'd0);
    accept();
    chk("beq_taken_clr", {31'd0, branch_taken}, 32'd0);
    issue({6'h05, 5'd1, 5'd2, 16'h0010}, 32'd9, 32'd9);
    chk("bne_taken", {31'd0, branch_taken}, 32'd0);
    chk("bne_wben", {31'd0, wb_en}, 32'd0);
    accept();

    // add $0,$1,$2 -- write to $zero suppressed
    issue({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'd5, 32'd7);
    chk("zero_wben", {31'd0, wb_en}, 32'd0);
    chk("zero_data", wb_data, 32'd12);
    accept();

    // illegal opcode, held for 5 cycles before acceptance
    out_ready = 1'b0;
    issue({6'h3F, 26'h0}, 32'd5, 32'd7);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_wben", {31'd0, wb_en}, 32'd0);
    chk("ill_ctr", {29'd0, ex_ctr}, 32'd5);
    chk("ill_src1", ex_src1, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, instr_ready}, 32'd0);
      chk("hold_ill", {31'd0, illegal}, 32'd1);
    end
    accept();
    chk("ill_clr", {31'd0, illegal}, 32'd0);

    // reset during EXEC of a beq (alu_ctr becomes 110 in DECODE)
    @(negedge clk);
    instr = {6'h04, 5'd1, 5'd2, 16'h0}; rs_data = 32'd1; rt_data = 32'd1; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_ctr", {29'd0, alu_ctr}, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_ctr", {29'd0, alu_ctr}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
